// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver: 2-FF input sync, 11-bit deframing, odd-parity/stop/timeout checks.
// Optional PS2_BREAK_FILTER_EN folds the F0 break prefix into is_break on the following code.
module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic [7:0] scancode,
  output logic       scan_valid,
  output logic       is_break,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          kclk_m_q, kclk_m_d, kclk_s_q, kclk_s_d, kclk_h_q, kclk_h_d;
  logic          kdat_m_q, kdat_m_d, kdat_s_q, kdat_s_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    scancode_q, scancode_d;
  logic          scan_valid_q, scan_valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          fe;
`ifdef PS2_BREAK_FILTER_EN
  logic          brk_pend_q, brk_pend_d;
  logic          is_break_q, is_break_d;
`endif

  assign fe = kclk_h_q & ~kclk_s_q;

  always_comb begin
    kclk_m_d     = kbdclk;
    kclk_s_d     = kclk_m_q;
    kclk_h_d     = kclk_s_q;
    kdat_m_d     = kbddat;
    kdat_s_d     = kdat_m_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_d        = '0;
    scancode_d   = scancode_q;
    scan_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    brk_pend_d   = brk_pend_q;
    is_break_d   = is_break_q;
`endif
    if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      par_d       = 1'b0;
      frame_err_d = 1'b1;
    end else begin
      if (state_q != S_IDLE && !fe) tmo_d = tmo_q + TW'(1);
      if (fe) begin
        unique case (state_q)
          S_IDLE: begin
            if (!kdat_s_q) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          S_DATA: begin
            shift_d = {kdat_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d   = S_PARITY;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
          S_PARITY: begin
            par_d   = kdat_s_q;
            state_d = S_STOP;
          end
          S_STOP: begin
            state_d = S_IDLE;
            if (!kdat_s_q) begin
              frame_err_d = 1'b1;
            end else if ((^shift_q ^ par_q) != 1'b1) begin
              parity_err_d = 1'b1;
            end else begin
`ifdef PS2_BREAK_FILTER_EN
              // F0 only arms the flag; the next accepted byte carries it out
              if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
              end else begin
                scan_valid_d = 1'b1;
                scancode_d   = shift_q;
                is_break_d   = brk_pend_q;
                brk_pend_d   = 1'b0;
              end
`else
              scan_valid_d = 1'b1;
              scancode_d   = shift_q;
`endif
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_m_q     <= 1'b1;
      kclk_s_q     <= 1'b1;
      kclk_h_q     <= 1'b1;
      kdat_m_q     <= 1'b1;
      kdat_s_q     <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      scancode_q   <= '0;
      scan_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      brk_pend_q   <= 1'b0;
      is_break_q   <= 1'b0;
`endif
    end else begin
      kclk_m_q     <= kclk_m_d;
      kclk_s_q     <= kclk_s_d;
      kclk_h_q     <= kclk_h_d;
      kdat_m_q     <= kdat_m_d;
      kdat_s_q     <= kdat_s_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      scancode_q   <= scancode_d;
      scan_valid_q <= scan_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_BREAK_FILTER_EN
      brk_pend_q   <= brk_pend_d;
      is_break_q   <= is_break_d;
`endif
    end
  end

  assign scancode   = scancode_q;
  assign scan_valid = scan_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
`ifdef PS2_BREAK_FILTER_EN
  assign is_break   = is_break_q;
`else
  assign is_break   = 1'b0;
`endif

endmodule
